// File: rtl/mem_req_arbiter.sv
// -----------------------------------------------------------------------------
// mem_req_arbiter
//
// Two-master to one-device memory request arbiter with in-order response
// routing.  Master 0 is the instruction side, master 1 the data side.
//
// Requests:
//   The granted master's payload is muxed straight onto out_req_*.  Once a
//   request is shown downstream but not accepted, the grant is locked so
//   the payload stays stable until it fires.
//
// Responses:
//   Every accepted request pushes its owner ID into a small owner FIFO.
//   Responses are routed combinationally to the master at the FIFO head.
//   A response that arrives with nothing outstanding is drained and
//   dropped, and it sets the sticky err_orphan_resp flag.
//
// Configuration:
//   ARB_ROUND_ROBIN_EN - when defined, round-robin arbitration (the
//                        last-granted master gets lowest priority next).
//                        When undefined, fixed priority with master 1
//                        winning any contention.
//
// Parameters:
//   OWNER_DEPTH - maximum number of outstanding downstream requests
//                 (power of two, >= 1).
// -----------------------------------------------------------------------------
module mem_req_arbiter #(
   parameter int OWNER_DEPTH = 2
) (
   input  logic        clock,
   input  logic        reset,

   // Master 0 (instruction side) request
   input  logic        m0_req_valid,
   output logic        m0_req_ready,
   input  logic [0:0]  m0_req_bits_is_cached,
   input  logic [31:0] m0_req_bits_addr,
   input  logic [1:0]  m0_req_bits_len,
   input  logic [31:0] m0_req_bits_data,
   input  logic [0:0]  m0_req_bits_func,
   input  logic [3:0]  m0_req_bits_strb,
   // Master 0 response
   output logic        m0_resp_valid,
   input  logic        m0_resp_ready,
   output logic [31:0] m0_resp_bits_data,

   // Master 1 (data side) request
   input  logic        m1_req_valid,
   output logic        m1_req_ready,
   input  logic [0:0]  m1_req_bits_is_cached,
   input  logic [31:0] m1_req_bits_addr,
   input  logic [1:0]  m1_req_bits_len,
   input  logic [31:0] m1_req_bits_data,
   input  logic [0:0]  m1_req_bits_func,
   input  logic [3:0]  m1_req_bits_strb,
   // Master 1 response
   output logic        m1_resp_valid,
   input  logic        m1_resp_ready,
   output logic [31:0] m1_resp_bits_data,

   // Downstream request
   output logic        out_req_valid,
   input  logic        out_req_ready,
   output logic [0:0]  out_req_bits_is_cached,
   output logic [31:0] out_req_bits_addr,
   output logic [1:0]  out_req_bits_len,
   output logic [31:0] out_req_bits_data,
   output logic [0:0]  out_req_bits_func,
   output logic [3:0]  out_req_bits_strb,

   // Downstream response
   input  logic        out_resp_valid,
   output logic        out_resp_ready,
   input  logic [31:0] out_resp_bits_data,

   // Sticky error: response received with nothing outstanding
   output logic        err_orphan_resp
);

   // Pointer width is at least one bit so OWNER_DEPTH = 1 still elaborates;
   // wrap is done explicitly against the last index rather than by overflow.
   localparam int PW = (OWNER_DEPTH > 1) ? $clog2(OWNER_DEPTH) : 1;
   localparam int CW = $clog2(OWNER_DEPTH + 1);

   localparam logic [CW-1:0] FULL_CNT = CW'(OWNER_DEPTH);
   localparam logic [PW-1:0] LAST_PTR = PW'(OWNER_DEPTH - 1);

   // Grant-lock state machine
   typedef enum logic [0:0] {
      ST_OPEN = 1'b0,   // arbitration free to choose each cycle
      ST_HELD = 1'b1    // a shown request is waiting; grant frozen
   } lock_state_e;

   lock_state_e     state_r;
   lock_state_e     state_s;
   logic            lock_id_r;
   logic            grant_held_s;

   // Arbitration and request path
   logic            grant_s;
   logic            gnt_valid_s;
   logic            req_fire_s;

   // Owner FIFO
   logic            owner_r [OWNER_DEPTH];
   logic [PW-1:0]   wr_ptr_r;
   logic [PW-1:0]   rd_ptr_r;
   logic [CW-1:0]   count_r;
   logic            full_s;
   logic            empty_s;
   logic            head_s;
   logic            push_s;
   logic            pop_s;

   // Response path
   logic            resp_fire_s;
   logic            orphan_r;

   assign full_s  = (count_r == FULL_CNT);
   assign empty_s = (count_r == {CW{1'b0}});
   assign head_s  = owner_r[rd_ptr_r];

`ifdef ARB_ROUND_ROBIN_EN
   logic            rr_ptr_r;

   // Round-robin pointer: after each accepted request the other master is preferred
   always_ff @(posedge clock) begin
      if (reset) begin
         rr_ptr_r <= 1'b0;
      end else if (req_fire_s) begin
         rr_ptr_r <= ~grant_s;
      end else begin
         rr_ptr_r <= rr_ptr_r;
      end
   end
`endif

   // Lock FSM state register; also captures the grant being frozen
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r   <= ST_OPEN;
         lock_id_r <= 1'b0;
      end else begin
         state_r <= state_s;
         if (out_req_valid && !out_req_ready) begin
            lock_id_r <= grant_s;
         end else begin
            lock_id_r <= lock_id_r;
         end
      end
   end

   // Lock FSM next state: hold from the first unaccepted show until the fire
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_OPEN: begin
            if (out_req_valid && !out_req_ready) begin
               state_s = ST_HELD;
            end else begin
               state_s = ST_OPEN;
            end
         end
         ST_HELD: begin
            if (req_fire_s) begin
               state_s = ST_OPEN;
            end else begin
               state_s = ST_HELD;
            end
         end
         default: begin
            state_s = ST_OPEN;
         end
      endcase
   end

   // Lock FSM outputs
   always_comb begin
      grant_held_s = 1'b0;
      case (state_r)
         ST_OPEN: grant_held_s = 1'b0;
         ST_HELD: grant_held_s = 1'b1;
         default: grant_held_s = 1'b0;
      endcase
   end

   // Grant selection: a held grant wins, otherwise arbitrate among valid masters
   always_comb begin
      grant_s = 1'b0;
      if (grant_held_s) begin
         grant_s = lock_id_r;
      end else if (m0_req_valid && m1_req_valid) begin
`ifdef ARB_ROUND_ROBIN_EN
         grant_s = rr_ptr_r;
`else
         grant_s = 1'b1;
`endif
      end else if (m1_req_valid) begin
         grant_s = 1'b1;
      end else begin
         grant_s = 1'b0;
      end
   end

   // Downstream payload mux driven from the granted master
   always_comb begin
      out_req_bits_is_cached = m0_req_bits_is_cached;
      out_req_bits_addr      = m0_req_bits_addr;
      out_req_bits_len       = m0_req_bits_len;
      out_req_bits_data      = m0_req_bits_data;
      out_req_bits_func      = m0_req_bits_func;
      out_req_bits_strb      = m0_req_bits_strb;
      if (grant_s) begin
         out_req_bits_is_cached = m1_req_bits_is_cached;
         out_req_bits_addr      = m1_req_bits_addr;
         out_req_bits_len       = m1_req_bits_len;
         out_req_bits_data      = m1_req_bits_data;
         out_req_bits_func      = m1_req_bits_func;
         out_req_bits_strb      = m1_req_bits_strb;
      end else begin
         out_req_bits_is_cached = m0_req_bits_is_cached;
         out_req_bits_addr      = m0_req_bits_addr;
         out_req_bits_len       = m0_req_bits_len;
         out_req_bits_data      = m0_req_bits_data;
         out_req_bits_func      = m0_req_bits_func;
         out_req_bits_strb      = m0_req_bits_strb;
      end
   end

   // Request handshake: only the granted master sees ready, and nothing passes when full
   always_comb begin
      gnt_valid_s   = grant_s ? m1_req_valid : m0_req_valid;
      out_req_valid = gnt_valid_s && !full_s;
      req_fire_s    = out_req_valid && out_req_ready;
      push_s        = req_fire_s;
      m0_req_ready  = 1'b0;
      m1_req_ready  = 1'b0;
      if (grant_s) begin
         m1_req_ready = out_req_ready && !full_s;
      end else begin
         m0_req_ready = out_req_ready && !full_s;
      end
   end

   // Response routing to the head owner; an empty FIFO drains stray responses
   always_comb begin
      m0_resp_valid     = 1'b0;
      m1_resp_valid     = 1'b0;
      m0_resp_bits_data = 32'h0000_0000;
      m1_resp_bits_data = 32'h0000_0000;
      out_resp_ready    = 1'b1;
      if (empty_s) begin
         out_resp_ready = 1'b1;
      end else if (head_s) begin
         m1_resp_valid     = out_resp_valid;
         m1_resp_bits_data = out_resp_bits_data;
         out_resp_ready    = m1_resp_ready;
      end else begin
         m0_resp_valid     = out_resp_valid;
         m0_resp_bits_data = out_resp_bits_data;
         out_resp_ready    = m0_resp_ready;
      end
      resp_fire_s = out_resp_valid && out_resp_ready;
      pop_s       = resp_fire_s && !empty_s;
   end

   // Owner FIFO storage and pointers; push and pop may share a cycle
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < OWNER_DEPTH; i++) begin
            owner_r[i] <= 1'b0;
         end
         wr_ptr_r <= {PW{1'b0}};
         rd_ptr_r <= {PW{1'b0}};
         count_r  <= {CW{1'b0}};
      end else begin
         if (push_s) begin
            owner_r[wr_ptr_r] <= grant_s;
            wr_ptr_r <= (wr_ptr_r == LAST_PTR) ? {PW{1'b0}} : wr_ptr_r + 1'b1;
         end else begin
            wr_ptr_r <= wr_ptr_r;
         end
         if (pop_s) begin
            rd_ptr_r <= (rd_ptr_r == LAST_PTR) ? {PW{1'b0}} : rd_ptr_r + 1'b1;
         end else begin
            rd_ptr_r <= rd_ptr_r;
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + 1'b1;
            2'b01:   count_r <= count_r - 1'b1;
            default: count_r <= count_r;
         endcase
      end
   end

   // Sticky orphan-response flag, cleared only by reset
   always_ff @(posedge clock) begin
      if (reset) begin
         orphan_r <= 1'b0;
      end else if (resp_fire_s && empty_s) begin
         orphan_r <= 1'b1;
      end else begin
         orphan_r <= orphan_r;
      end
   end

   assign err_orphan_resp = orphan_r;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_req_arbiter
//
// Directed stimulus with a behavioural model (owner queue, grant rules,
// sticky orphan flag) checked against the DUT every cycle on the falling
// edge, plus hand-computed literal expectations for the key scenarios.
// -----------------------------------------------------------------------------
module tb_mem_req_arbiter;

   localparam int DEPTH = 2;

   logic        clock = 1'b0;
   logic        reset;

   logic        m_valid [2];
   logic        m_resp_ready [2];
   logic [0:0]  m_is_cached [2];
   logic [31:0] m_addr [2];
   logic [1:0]  m_len [2];
   logic [31:0] m_data [2];
   logic [0:0]  m_func [2];
   logic [3:0]  m_strb [2];

   logic        m0_req_ready, m1_req_ready;
   logic        m0_resp_valid, m1_resp_valid;
   logic [31:0] m0_resp_bits_data, m1_resp_bits_data;

   logic        out_req_valid;
   logic        out_req_ready;
   logic [0:0]  out_req_bits_is_cached;
   logic [31:0] out_req_bits_addr;
   logic [1:0]  out_req_bits_len;
   logic [31:0] out_req_bits_data;
   logic [0:0]  out_req_bits_func;
   logic [3:0]  out_req_bits_strb;

   logic        out_resp_valid;
   logic        out_resp_ready;
   logic [31:0] out_resp_bits_data;
   logic        err_orphan_resp;

   int tests_run = 0;
   int tests_failed = 0;

   always #5 clock = ~clock;

   mem_req_arbiter #(.OWNER_DEPTH(DEPTH)) dut (
      .clock                 (clock),
      .reset                 (reset),
      .m0_req_valid          (m_valid[0]),
      .m0_req_ready          (m0_req_ready),
      .m0_req_bits_is_cached (m_is_cached[0]),
      .m0_req_bits_addr      (m_addr[0]),
      .m0_req_bits_len       (m_len[0]),
      .m0_req_bits_data      (m_data[0]),
      .m0_req_bits_func      (m_func[0]),
      .m0_req_bits_strb      (m_strb[0]),
      .m0_resp_valid         (m0_resp_valid),
      .m0_resp_ready         (m_resp_ready[0]),
      .m0_resp_bits_data     (m0_resp_bits_data),
      .m1_req_valid          (m_valid[1]),
      .m1_req_ready          (m1_req_ready),
      .m1_req_bits_is_cached (m_is_cached[1]),
      .m1_req_bits_addr      (m_addr[1]),
      .m1_req_bits_len       (m_len[1]),
      .m1_req_bits_data      (m_data[1]),
      .m1_req_bits_func      (m_func[1]),
      .m1_req_bits_strb      (m_strb[1]),
      .m1_resp_valid         (m1_resp_valid),
      .m1_resp_ready         (m_resp_ready[1]),
      .m1_resp_bits_data     (m1_resp_bits_data),
      .out_req_valid         (out_req_valid),
      .out_req_ready         (out_req_ready),
      .out_req_bits_is_cached(out_req_bits_is_cached),
      .out_req_bits_addr     (out_req_bits_addr),
      .out_req_bits_len      (out_req_bits_len),
      .out_req_bits_data     (out_req_bits_data),
      .out_req_bits_func     (out_req_bits_func),
      .out_req_bits_strb     (out_req_bits_strb),
      .out_resp_valid        (out_resp_valid),
      .out_resp_ready        (out_resp_ready),
      .out_resp_bits_data    (out_resp_bits_data),
      .err_orphan_resp       (err_orphan_resp)
   );

   task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   // Derive a distinctive full payload for master id from its address
   task automatic drive_m(input int id, input logic v, input logic [31:0] a);
      m_valid[id]     = v;
      m_addr[id]      = a;
      m_is_cached[id] = a[12];
      m_len[id]       = a[13:12];
      m_data[id]      = ~a;
      m_func[id]      = a[14];
      m_strb[id]      = a[15:12];
   endtask

   function automatic logic [71:0] pay_of(input int id);
      return {m_is_cached[id], m_addr[id], m_len[id], m_data[id], m_func[id], m_strb[id]};
   endfunction

   function automatic logic [71:0] dut_pay();
      return {out_req_bits_is_cached, out_req_bits_addr, out_req_bits_len,
              out_req_bits_data, out_req_bits_func, out_req_bits_strb};
   endfunction

   // ---------------- behavioural model + per-cycle compare ----------------
   int q[$];
   bit lk = 1'b0;
   int lk_id = 0;
   int pref = 0;
   bit orph = 1'b0;

   initial begin
      @(posedge clock);
      forever begin
         int  g;
         bit  full, empty, anyv, ev, exp_rr;
         int  head;
         @(negedge clock);
         full  = (q.size() == DEPTH);
         empty = (q.size() == 0);
         head  = empty ? 0 : q[0];
         anyv  = m_valid[0] || m_valid[1];
         if (lk) g = lk_id;
         else if (m_valid[0] && m_valid[1]) begin
`ifdef ARB_ROUND_ROBIN_EN
            g = pref;
`else
            g = 1;
`endif
         end
         else if (m_valid[1]) g = 1;
         else g = 0;
         ev     = m_valid[g] && !full;
         exp_rr = empty ? 1'b1 : m_resp_ready[head];

         chk("model out_req_valid", 72'(out_req_valid), 72'(ev));
         if (ev) chk("model out_req_bits", dut_pay(), pay_of(g));
         if (anyv || lk) begin
            chk("model m0_req_ready", 72'(m0_req_ready), 72'((g == 0) && out_req_ready && !full));
            chk("model m1_req_ready", 72'(m1_req_ready), 72'((g == 1) && out_req_ready && !full));
         end
         chk("model m0_resp_valid", 72'(m0_resp_valid), 72'(!empty && head == 0 && out_resp_valid));
         chk("model m1_resp_valid", 72'(m1_resp_valid), 72'(!empty && head == 1 && out_resp_valid));
         if (!empty && out_resp_valid)
            chk("model resp_data", 72'(head ? m1_resp_bits_data : m0_resp_bits_data),
                72'(out_resp_bits_data));
         chk("model out_resp_ready", 72'(out_resp_ready), 72'(exp_rr));
         chk("model err_orphan", 72'(err_orphan_resp), 72'(orph));

         // advance the model to the state after the coming rising edge
         if (reset) begin
            q.delete();
            lk = 1'b0; pref = 0; orph = 1'b0;
         end else begin
            if (out_resp_valid && exp_rr) begin
               if (empty) orph = 1'b1;
               else void'(q.pop_front());
            end
            if (ev && out_req_ready) begin
               q.push_back(g);
               pref = 1 - g;
               lk = 1'b0;
            end else if (ev) begin
               lk = 1'b1;
               lk_id = g;
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // ---------------- directed stimulus with literal expectations ----------------
   initial begin
      int fires;
      int gnt [4];
      int exp_gnt [4];

      reset = 1'b1;
      drive_m(0, 1'b0, 32'h0); drive_m(1, 1'b0, 32'h0);
      m_resp_ready[0] = 1'b1; m_resp_ready[1] = 1'b1;
      out_req_ready = 1'b0; out_resp_valid = 1'b0; out_resp_bits_data = 32'h0;

      // reset state
      cyc(); #1;
      chk("rst out_resp_ready", 72'(out_resp_ready), 72'd1);
      chk("rst m0_resp_valid", 72'(m0_resp_valid), 72'd0);
      chk("rst m1_resp_valid", 72'(m1_resp_valid), 72'd0);
      chk("rst out_req_valid", 72'(out_req_valid), 72'd0);
      chk("rst err", 72'(err_orphan_resp), 72'd0);
      cyc(); cyc(); reset = 1'b0;

      // single read from master 0, response one cycle later
      cyc(); drive_m(0, 1'b1, 32'h0000_1000); out_req_ready = 1'b1;
      #1 chk("t1 out_req_addr", 72'(out_req_bits_addr), 72'h1000);
      chk("t1 m0_req_ready", 72'(m0_req_ready), 72'd1);
      chk("t1 m1_req_ready", 72'(m1_req_ready), 72'd0);
      cyc(); drive_m(0, 1'b0, 32'h0000_1000);
      out_resp_valid = 1'b1; out_resp_bits_data = 32'hDEAD_BEEF;
      #1 chk("t1 m0_resp_valid", 72'(m0_resp_valid), 72'd1);
      chk("t1 m0_resp_data", 72'(m0_resp_bits_data), 72'hDEAD_BEEF);
      chk("t1 m1_resp_valid", 72'(m1_resp_valid), 72'd0);
      cyc(); out_resp_valid = 1'b0;

      // reset so arbitration history starts fresh, then contention
      cyc(); reset = 1'b1;
      cyc(); reset = 1'b0;
      drive_m(0, 1'b1, 32'h0000_2000); drive_m(1, 1'b1, 32'h0000_3000);
      for (int k = 0; k < 4; k++) begin
         #1 gnt[k] = m1_req_ready ? 1 : 0;
         cyc();
         out_resp_valid = 1'b1; out_resp_bits_data = 32'hA000_0000 + 32'(k);
      end
      drive_m(0, 1'b0, 32'h0); drive_m(1, 1'b0, 32'h0);
      cyc(); out_resp_valid = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      exp_gnt = '{0, 1, 0, 1};
`else
      exp_gnt = '{1, 1, 1, 1};
`endif
      for (int k = 0; k < 4; k++) chk("t2 grant", 72'(gnt[k]), 72'(exp_gnt[k]));

      // owner FIFO fills after two requests with no responses
      cyc(); drive_m(0, 1'b1, 32'h0000_6000); out_req_ready = 1'b1;
      fires = 0;
      for (int i = 0; i < 4; i++) begin
         #1 if (out_req_valid && out_req_ready) fires++;
         cyc();
      end
      chk("t3 fire count", 72'(fires), 72'd2);
      drive_m(1, 1'b1, 32'h0000_7000);
      #1 chk("t3 full out_req_valid", 72'(out_req_valid), 72'd0);
      chk("t3 full m0_req_ready", 72'(m0_req_ready), 72'd0);
      chk("t3 full m1_req_ready", 72'(m1_req_ready), 72'd0);
      cyc(); out_resp_valid = 1'b1; out_resp_bits_data = 32'h0000_0066;
      #1 chk("t3 pop-cycle out_req_valid", 72'(out_req_valid), 72'd0);
      chk("t3 pop m0_resp_valid", 72'(m0_resp_valid), 72'd1);
      cyc(); drive_m(0, 1'b0, 32'h0); drive_m(1, 1'b0, 32'h0);
      out_resp_bits_data = 32'h0000_0067;
      cyc(); out_resp_valid = 1'b0;

      // grant lock while downstream stalls
      cyc(); drive_m(0, 1'b1, 32'h0000_4000); out_req_ready = 1'b0;
      #1 chk("t4 c1 addr", 72'(out_req_bits_addr), 72'h4000);
      cyc(); drive_m(1, 1'b1, 32'h0000_5000);
      #1 chk("t4 c2 payload", dut_pay(), pay_of(0));
      cyc();
      #1 chk("t4 c3 addr", 72'(out_req_bits_addr), 72'h4000);
      cyc(); out_req_ready = 1'b1;
      #1 chk("t4 fire addr", 72'(out_req_bits_addr), 72'h4000);
      chk("t4 fire m0_req_ready", 72'(m0_req_ready), 72'd1);
      chk("t4 fire m1_req_ready", 72'(m1_req_ready), 72'd0);
      cyc(); drive_m(0, 1'b0, 32'h0);
      #1 chk("t4 m1 addr", 72'(out_req_bits_addr), 72'h5000);
      cyc(); drive_m(1, 1'b0, 32'h0);
      out_resp_valid = 1'b1; out_resp_bits_data = 32'h0000_0011;
      #1 chk("t4 r1 m0_resp_valid", 72'(m0_resp_valid), 72'd1);
      cyc(); out_resp_bits_data = 32'h0000_0022;
      #1 chk("t4 r2 m1_resp_valid", 72'(m1_resp_valid), 72'd1);
      chk("t4 r2 m0_resp_valid", 72'(m0_resp_valid), 72'd0);
      cyc(); out_resp_valid = 1'b0;

      // orphan response with FIFO empty
      cyc(); out_resp_valid = 1'b1; out_resp_bits_data = 32'h0000_0BAD;
      #1 chk("t5 out_resp_ready", 72'(out_resp_ready), 72'd1);
      chk("t5 m0_resp_valid", 72'(m0_resp_valid), 72'd0);
      chk("t5 m1_resp_valid", 72'(m1_resp_valid), 72'd0);
      chk("t5 err before", 72'(err_orphan_resp), 72'd0);
      cyc(); out_resp_valid = 1'b0;
      #1 chk("t5 err set", 72'(err_orphan_resp), 72'd1);
      cyc(); cyc();
      #1 chk("t5 err sticky", 72'(err_orphan_resp), 72'd1);

      // reset with a request outstanding, then its response arrives
      cyc(); reset = 1'b1;
      cyc(); reset = 1'b0;
      #1 chk("t6 err cleared", 72'(err_orphan_resp), 72'd0);
      drive_m(0, 1'b1, 32'h0000_8000); out_req_ready = 1'b1;
      cyc(); drive_m(0, 1'b0, 32'h0); reset = 1'b1;
      cyc(); reset = 1'b0;
      m_resp_ready[0] = 1'b0;
      out_resp_valid = 1'b1; out_resp_bits_data = 32'h0000_0099;
      #1 chk("t6 m0_resp_valid", 72'(m0_resp_valid), 72'd0);
      chk("t6 m1_resp_valid", 72'(m1_resp_valid), 72'd0);
      chk("t6 out_resp_ready", 72'(out_resp_ready), 72'd1);
      cyc(); out_resp_valid = 1'b0; m_resp_ready[0] = 1'b1;
      #1 chk("t6 err set", 72'(err_orphan_resp), 72'd1);

      cyc(); cyc();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/mem_req_arbiter.md
MEM_REQ_ARBITER -- requirements
Module: mem_req_arbiter

Interface
REQ-001 Parameter OWNER_DEPTH, default 2: depth of the response-owner FIFO, i.e. the maximum number of outstanding downstream requests; must be a power of two and at least 1.
REQ-002 Port clock, input, 1: sole clock; all state updates on its rising edge.
REQ-003 Port reset, input, 1: synchronous, active-high reset.
REQ-004 Ports m0_req_valid in 1, m0_req_ready out 1: request handshake for master 0 (instruction side).
REQ-005 Ports m0_req_bits_{is_cached[0:0], addr[31:0], len[1:0], data[31:0], func[0:0], strb[3:0]}, all inputs: request payload for master 0.
REQ-006 Ports m0_resp_valid out 1, m0_resp_ready in 1, m0_resp_bits_data out 32: response channel for master 0.
REQ-007 Ports m1_*: identical set to REQ-004..006 for master 1 (data side).
REQ-008 Ports out_req_valid out 1, out_req_ready in 1, out_req_bits_* outputs with the same widths as REQ-005: downstream request to the device.
REQ-009 Ports out_resp_valid in 1, out_resp_ready out 1, out_resp_bits_data in 32: downstream response.
REQ-010 Port err_orphan_resp, output, 1: sticky flag for a response received with no request outstanding.

Function
REQ-011 A transfer fires on any channel when valid and ready are both high in the same cycle.
REQ-012 out_req_bits_* is combinationally selected from the granted master; out_req_valid = granted master's req_valid AND owner FIFO not full.
REQ-013 Only the granted master's req_ready may be high; it equals out_req_ready AND FIFO not full. The other master's req_ready is 0.
REQ-014 Arbitration applies only when no grant lock is held; the grant is evaluated combinationally among the masters whose req_valid is high.
REQ-015 Grant lock: when out_req_valid is 1 and out_req_ready is 0, the current grant is registered and held until that request fires. Once out_req_valid is shown, its payload and grant do not change until it fires.
REQ-016 Each out_req fire pushes the owner ID (0 or 1) into the owner FIFO in the same edge.
REQ-017 The FIFO is full when it holds OWNER_DEPTH entries. When full, requests are blocked. A push while full is not possible, even in a cycle where a pop occurs.
REQ-018 out_resp is routed to the master at the FIFO head: that master's resp_valid = out_resp_valid, and its resp_bits_data = out_resp_bits_data. The other master's resp_valid is 0.
REQ-019 When the FIFO is non-empty, out_resp_ready = the head master's resp_ready. An out_resp fire pops the head.
REQ-020 Push and pop may occur in the same cycle; the count is then unchanged. FIFO pointers wrap modulo OWNER_DEPTH.
REQ-021 When the FIFO is empty:
- out_resp_ready = 1, so stray responses are drained and dropped;
- a fire in this state sets err_orphan_resp, which remains 1 until reset.
REQ-022 Responses are delivered to masters in request-issue order, with zero added latency: combinational pass-through.
REQ-023 There is no combinational path from out_resp_* to out_req_*, nor from out_req_ready to any resp output.

Reset
REQ-024 While reset is 1:
- FIFO count and pointers = 0;
- grant lock cleared;
- round-robin pointer = 0 (master 0 preferred);
- err_orphan_resp = 0.
REQ-025 Consequently, during and immediately after reset:
- out_req_valid = 0 unless a master is requesting;
- all resp_valid = 0;
- out_resp_ready = 1.
REQ-026 Reset asserted mid-transaction discards all outstanding ownership. Responses arriving afterwards are treated as orphans per REQ-021.

Configuration
REQ-027 Macro ARB_ROUND_ROBIN_EN.
- Defined: round-robin arbitration. The last-granted master has lowest priority next; the pointer updates on each out_req fire.
- Undefined: fixed priority. Master 1 always wins when both are valid, and no pointer register exists.

Verification
REQ-028 Master 0 alone issues read addr=0x1000. Device responds 0xDEADBEEF one cycle later -> m0_resp_valid=1 with data 0xDEADBEEF; m1_resp_valid stays 0.
REQ-029 Both masters valid every cycle, out_req_ready=1, and responses returned in order.
- With ARB_ROUND_ROBIN_EN: grants alternate 0,1,0,1.
- Without it: every grant goes to master 1 and master 0 is starved.
REQ-030 OWNER_DEPTH=2, out_req_ready=1, out_resp_valid held 0 -> exactly two requests fire, then out_req_valid=0 and both req_ready=0 until a response pops.
REQ-031 out_req_ready held 0 for 3 cycles while master 1 becomes valid in cycle 2 (master 0 granted first) -> out_req_bits_addr stays at master 0's address and the grant stays 0 until fire.
REQ-032 A response is injected with the FIFO empty -> out_resp_ready=1 and the response is dropped; err_orphan_resp=1 from the next cycle and stays 1 until reset.
REQ-033 Reset asserted with one request outstanding, then a response arrives -> response dropped and err_orphan_resp=1; both masters' resp_valid stay 0.
